// File: rtl/onehot_enc_pkg.sv
// onehot_enc_pkg: shared types and index-width helper for the one-hot encoder pipe
package onehot_enc_pkg;
  typedef enum logic {PRIO_LSB, PRIO_MSB} prio_e;
  typedef enum logic {EMPTY, FULL} pipe_state_e;
  function automatic int idx_w(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/onehot_encoder_pipe_if.sv
// onehot_encoder_pipe_if: input/output valid-ready beat signals of the encoder pipe
interface onehot_encoder_pipe_if #(
  parameter int IN_W = 16,
  parameter int OUT_W = 4
);
  logic in_valid;
  logic in_ready;
  logic [IN_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [OUT_W-1:0] out_index;
  logic out_zero;
  logic out_multi;
  modport master (
    output in_valid, in_data, out_ready,
    input in_ready, out_valid, out_index, out_zero, out_multi
  );
  modport slave (
    input in_valid, in_data, out_ready,
    output in_ready, out_valid, out_index, out_zero, out_multi
  );
endinterface

// File: rtl/onehot_enc_core.sv
// onehot_enc_core: combinational one-hot to binary encoder with zero/multi-hot flags
module onehot_enc_core #(
  parameter int IN_W = 16,
  parameter int PRIO_MSB = 0,
  localparam int OUT_W = onehot_enc_pkg::idx_w(IN_W)
) (
  input logic [IN_W-1:0] data,
  input logic enable,
  output logic [OUT_W-1:0] index,
  output logic zero,
  output logic multi
);
  localparam onehot_enc_pkg::prio_e PRIO = (PRIO_MSB != 0) ? onehot_enc_pkg::PRIO_MSB : onehot_enc_pkg::PRIO_LSB;
  localparam bit MSB_FIRST = PRIO == onehot_enc_pkg::PRIO_MSB;
  logic [OUT_W-1:0] idx;
  logic hit;
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < IN_W; i++)
      if (!hit && data[MSB_FIRST ? IN_W-1-i : i]) begin
        idx = OUT_W'(MSB_FIRST ? IN_W-1-i : i);
        hit = 1'b1;
      end
  end
  assign index = enable ? idx : '0;
  assign zero = enable && ~|data;
  assign multi = enable && |(data & (data - IN_W'(1)));
endmodule

// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: registered one-hot encoder with valid/ready handshake and saturating error count
module onehot_encoder_pipe #(
  parameter int IN_W = 16,
  parameter int PRIO_MSB = 0,
  parameter int ERR_CNT_W = 8,
  localparam int OUT_W = onehot_enc_pkg::idx_w(IN_W)
) (
  input logic clk,
  input logic rst_n,
  input logic enable,
  input logic err_clr,
  onehot_encoder_pipe_if.slave pipe,
  output logic [ERR_CNT_W-1:0] err_count
);
  onehot_enc_pkg::pipe_state_e state, state_nxt;
  logic [OUT_W-1:0] enc_index;
  logic enc_zero;
  logic enc_multi;
  logic accept;
  onehot_enc_core #(.IN_W(IN_W), .PRIO_MSB(PRIO_MSB)) u_core (
    .data(pipe.in_data),
    .enable(enable),
    .index(enc_index),
    .zero(enc_zero),
    .multi(enc_multi)
  );
  always_comb begin
    pipe.in_ready = state == onehot_enc_pkg::EMPTY || pipe.out_ready;
    accept = pipe.in_valid && pipe.in_ready;
    state_nxt = (accept || (state == onehot_enc_pkg::FULL && !pipe.out_ready)) ? onehot_enc_pkg::FULL : onehot_enc_pkg::EMPTY;
  end
  assign pipe.out_valid = state == onehot_enc_pkg::FULL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= onehot_enc_pkg::EMPTY;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pipe.out_index <= '0;
      pipe.out_zero <= 1'b0;
      pipe.out_multi <= 1'b0;
    end else if (accept) begin
      pipe.out_index <= enc_index;
      pipe.out_zero <= enc_zero;
      pipe.out_multi <= enc_multi;
    end
  // clear beats a same-cycle increment; count sticks at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_count <= '0;
    else if (err_clr) err_count <= '0;
    else if (accept && (enc_zero || enc_multi) && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// tb_onehot_encoder_pipe: table, directed and random checks of LSB- and MSB-priority encoder pipes
module tb_onehot_encoder_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic err_clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic [7:0] ec0;
  logic [1:0] ec1;
  int checks = 0;
  int errors = 0;
  bit mv;
  int mi[2];
  bit mz[2];
  bit mm[2];
  int mc[2];
  int cmax[2] = '{255, 3};
  typedef struct {
    logic [15:0] d;
    bit en;
    int i0;
    int i1;
    bit z;
    bit m;
  } vec_t;
  vec_t tbl[8];
  onehot_encoder_pipe_if #(.IN_W(16), .OUT_W(4)) if0 ();
  onehot_encoder_pipe_if #(.IN_W(16), .OUT_W(4)) if1 ();
  assign if0.in_valid = in_valid;
  assign if0.in_data = in_data;
  assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid;
  assign if1.in_data = in_data;
  assign if1.out_ready = out_ready;
  onehot_encoder_pipe #(.IN_W(16), .PRIO_MSB(0), .ERR_CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .err_clr(err_clr), .pipe(if0), .err_count(ec0));
  onehot_encoder_pipe #(.IN_W(16), .PRIO_MSB(1), .ERR_CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .err_clr(err_clr), .pipe(if1), .err_count(ec1));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  function automatic void ref_enc(input logic [15:0] d, input bit en, input bit msb, output int idx, output bit z, output bit m);
    int pos[$];
    for (int i = 0; i < 16; i++) if (d[i]) pos.push_back(i);
    idx = (en && pos.size() > 0) ? (msb ? pos[pos.size()-1] : pos[0]) : 0;
    z = en && pos.size() == 0;
    m = en && pos.size() > 1;
  endfunction
  task automatic model_reset();
    mv = 0;
    for (int k = 0; k < 2; k++) begin
      mi[k] = 0; mz[k] = 0; mm[k] = 0; mc[k] = 0;
    end
  endtask
  task automatic check_outs(input string tag);
    logic ov[2];
    logic [3:0] oi[2];
    logic oz[2];
    logic om[2];
    logic [7:0] oc[2];
    ov[0] = if0.out_valid; ov[1] = if1.out_valid;
    oi[0] = if0.out_index; oi[1] = if1.out_index;
    oz[0] = if0.out_zero; oz[1] = if1.out_zero;
    om[0] = if0.out_multi; om[1] = if1.out_multi;
    oc[0] = ec0; oc[1] = {6'd0, ec1};
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s out_valid%0d", tag, k), ov[k], mv);
      chk($sformatf("%s err_count%0d", tag, k), oc[k], mc[k]);
      if (mv) begin
        chk($sformatf("%s out_index%0d", tag, k), oi[k], mi[k]);
        chk($sformatf("%s out_zero%0d", tag, k), oz[k], mz[k]);
        chk($sformatf("%s out_multi%0d", tag, k), om[k], mm[k]);
      end
    end
  endtask
  task automatic cyc(input string tag, input bit v, input logic [15:0] d, input bit r, input bit en, input bit clr);
    bit acc;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r; enable = en; err_clr = clr;
    #1;
    acc = v && (!mv || r);
    chk({tag, " in_ready0"}, if0.in_ready, !mv || r);
    chk({tag, " in_ready1"}, if1.in_ready, !mv || r);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (clr) mc[k] = 0;
      else if (acc && en && $countones(d) != 1 && mc[k] < cmax[k]) mc[k]++;
      if (acc) ref_enc(d, en, k == 1, mi[k], mz[k], mm[k]);
    end
    mv = acc || (mv && !r);
    check_outs(tag);
  endtask
  initial begin
    tbl[0] = '{16'h0040, 1, 6, 6, 0, 0};
    tbl[1] = '{16'h8000, 1, 15, 15, 0, 0};
    tbl[2] = '{16'h0001, 1, 0, 0, 0, 0};
    tbl[3] = '{16'h0000, 1, 0, 0, 1, 0};
    tbl[4] = '{16'h0014, 1, 2, 4, 0, 1};
    tbl[5] = '{16'h0000, 0, 0, 0, 0, 0};
    tbl[6] = '{16'h0014, 0, 0, 0, 0, 0};
    tbl[7] = '{16'hffff, 1, 0, 15, 0, 1};
    model_reset();
    #12;
    chk("reset out_valid0", if0.out_valid, 0);
    chk("reset out_valid1", if1.out_valid, 0);
    chk("reset out_index0", if0.out_index, 0);
    chk("reset out_zero0", if0.out_zero, 0);
    chk("reset out_multi0", if0.out_multi, 0);
    chk("reset err_count0", ec0, 0);
    chk("reset err_count1", ec1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("tbl%0d", i), 1, tbl[i].d, 1, tbl[i].en, 0);
      chk($sformatf("tbl%0d valid", i), if0.out_valid, 1);
      chk($sformatf("tbl%0d index0", i), if0.out_index, tbl[i].i0);
      chk($sformatf("tbl%0d index1", i), if1.out_index, tbl[i].i1);
      chk($sformatf("tbl%0d zero", i), if0.out_zero, tbl[i].z);
      chk($sformatf("tbl%0d multi", i), if0.out_multi, tbl[i].m);
    end
    chk("tbl err_count0", ec0, 3);
    chk("tbl err_count1", ec1, 3);
    cyc("drain", 0, 16'h0000, 1, 1, 0);
    cyc("bp load", 1, 16'h0100, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("bp hold", 1, 16'h0200, 0, 1, 0);
      chk("bp hold index", if0.out_index, 8);
      chk("bp hold in_ready", if0.in_ready, 0);
    end
    cyc("bp release", 1, 16'h0200, 1, 1, 0);
    chk("bp second beat", if0.out_index, 9);
    chk("bp second valid", if0.out_valid, 1);
    cyc("bp drain", 0, 16'h0000, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc("sat", 1, 16'h0000, 1, 1, 0);
    chk("sat err_count1", ec1, 3);
    cyc("clr", 1, 16'h0003, 1, 1, 1);
    chk("clr err_count0", ec0, 0);
    chk("clr err_count1", ec1, 0);
    cyc("pre rst", 1, 16'h0004, 0, 1, 0);
    chk("pre rst valid", if0.out_valid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid0", if0.out_valid, 0);
    chk("async rst out_valid1", if1.out_valid, 0);
    chk("async rst err_count0", ec0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post rst", 1, 16'h0008, 1, 1, 0);
    chk("post rst index", if0.out_index, 3);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0: d = '0;
        1: d = 16'h1 << $urandom_range(0, 15);
        default: d = 16'($urandom);
      endcase
      cyc("rand", $urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0,
          $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/onehot_encoder_pipe.md
Name: onehot_encoder_pipe

Overview:
Parametrised, registered one-hot-to-binary encoder with a valid/ready handshake on both sides. It generalises the fixed 16-to-4 combinational encoder in three ways: configurable input width, selectable priority direction for multi-hot inputs, and error detection with a saturating error counter. It sits between a one-hot request/status source and a consumer that needs a binary index, and it is triplication-friendly (pure synchronous state, no latches).

Parameters:
IN_W, 16, one-hot input width; legal range >= 2.
PRIO_MSB, 0, multi-hot resolution: 0 = lowest set bit wins, 1 = highest set bit wins.
ERR_CNT_W, 8, width of the saturating error counter.
OUT_W (derived, not overridable), $clog2(IN_W), width of the output index.

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  encode enable; when low, accepted beats encode to index 0 with no flags
err_clr  input  1  synchronous clear of err_count
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_data  input  IN_W  one-hot (expected) input vector
out_valid  output  1  output register holds a beat
out_ready  input  1  consumer accepts when out_valid && out_ready
out_index  output  OUT_W  binary index of selected set bit
out_zero  output  1  beat had no bit set (enable high)
out_multi  output  1  beat had more than one bit set (enable high)
err_count  output  ERR_CNT_W  count of zero/multi-hot beats, saturating

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_index=0, out_zero=0, out_multi=0, err_count=0. A beat held in the output register when reset asserts is dropped.
- Output register is a 2-state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
- EMPTY + accept -> FULL. FULL + out_ready + accept -> FULL (new beat loaded, full throughput). FULL + out_ready + no accept -> EMPTY. FULL + !out_ready -> FULL, holding its contents.
- Latency: 1 cycle from accepted input to out_valid.
- While out_valid && !out_ready, out_index, out_zero and out_multi stay stable.
- Encoding (enable=1): exactly one bit k set -> index=k, zero=0, multi=0. No bit set -> index=0, zero=1. Two or more bits set -> index = lowest set bit (PRIO_MSB=0) or highest set bit (PRIO_MSB=1), multi=1.
- Encoding (enable=0): index=0, zero=0, multi=0, whatever in_data holds; the beat still passes through the handshake.
- err_count increments by 1 on each accepted beat with enable=1 and (zero or multi). It saturates at 2^ERR_CNT_W-1 and never wraps.
- err_clr=1 sets err_count to 0 on the next edge. err_clr has priority over an increment in the same cycle; that increment is lost.
- in_data with X/unknown bits is outside the contract. No assertion is required on in_data while in_valid=0.

Decomposition:
- Package onehot_enc_pkg: function to compute the index width (max(1,$clog2(w))), and the prio_e enum (PRIO_LSB, PRIO_MSB).
- Sub-module onehot_enc_core: purely combinational. Parametrised by IN_W and PRIO_MSB. Inputs are data and enable; outputs are index, zero and multi.
- Top-level onehot_encoder_pipe: holds the handshake, the output register and the error counter.

Test Plan:
1. IN_W=16, PRIO_MSB=0; reset, then in_data=16'h0040 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, out_index=6, out_zero=0, out_multi=0. Then 16'h8000 -> 15, and 16'h0001 -> 0, back-to-back at one beat per cycle.
2. in_data=16'h0000 -> out_index=0, out_zero=1, err_count=1. Then in_data=16'h0014 -> out_index=2, out_multi=1, err_count=2. Repeat with PRIO_MSB=1 -> out_index=4.
3. Backpressure: hold out_ready=0 with the register FULL -> in_ready=0, out_index stable over 3 cycles, second beat not accepted. Raise out_ready for one cycle with in_valid=1 -> second beat loaded, no bubble, no loss.
4. ERR_CNT_W=2: 5 error beats -> err_count=3 (saturated). err_clr=1 in the same cycle as an error beat -> err_count=0.
5. enable=0 with in_data=16'h0000, then 16'h0014 -> out_index=0, flags 0, err_count unchanged, each beat still produces out_valid.
6. Assert rst_n=0 mid-cycle while out_valid=1 -> out_valid=0 immediately (before the next clk edge), err_count=0. After release, the first accepted beat appears 1 cycle later.
